// File: rtl/gpio_bank.sv
// AXI4-Lite GPIO bank: per-channel OUT/DIR/IN/IRQ_EN/IRQ_STAT registers, write response 1 cycle after AW+W,
// read data 1 cycle after AR; AW/W held independently, no new request accepted while B or R is outstanding.
module gpio_bank #(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_WIDTH  = $clog2(CHANNELS) + 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [CHANNELS*DATA_WIDTH-1:0] gpio_out,
  output logic [CHANNELS*DATA_WIDTH-1:0] gpio_oe,
  input  logic [CHANNELS*DATA_WIDTH-1:0] gpio_in,
  output logic                           irq
);
  localparam int                    NB    = DATA_WIDTH / 8;
  localparam int                    CW    = CHANNELS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LP_CH = ADDR_WIDTH'(CHANNELS);

  logic                  r_aw_held, r_w_held, r_bvalid, r_rvalid, r_irq;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [NB-1:0]         r_wstrb;
  logic [1:0]            r_bresp, r_rresp;
  logic [CW-1:0]         r_sync [SYNC_STAGES];
  logic [CW-1:0]         r_prev;

  logic                  w_aw_fire, w_w_fire, w_ar_fire, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr, w_wr_ch, w_rd_ch;
  logic [2:0]            w_wr_off, w_rd_off;
  logic                  w_wr_ok, w_rd_ok;
  logic [DATA_WIDTH-1:0] w_wdat, w_mask, w_rd_dat;
  logic [NB-1:0]         w_strb;
  logic [CW-1:0]         w_sync, w_edge, w_en_flat, w_stat_flat;
  logic                  w_unused;

  assign awready   = !r_aw_held && !r_bvalid;
  assign wready    = !r_w_held && !r_bvalid;
  assign arready   = !r_rvalid;
  assign bvalid    = r_bvalid;
  assign bresp     = r_bresp;
  assign rvalid    = r_rvalid;
  assign rresp     = r_rresp;
  assign rdata     = r_rdata;
  assign irq       = r_irq;

  assign w_aw_fire = awvalid && awready;
  assign w_w_fire  = wvalid && wready;
  assign w_ar_fire = arvalid && arready;
  assign w_commit  = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);

  // Held beats take priority; otherwise the beat handshaking this cycle is used directly.
  assign w_waddr   = r_aw_held ? r_awaddr : awaddr;
  assign w_wdat    = r_w_held ? r_wdata : wdata;
  assign w_strb    = r_w_held ? r_wstrb : wstrb;
  assign w_wr_ch   = w_waddr >> 5;
  assign w_wr_off  = w_waddr[4:2];
  assign w_wr_ok   = w_wr_ch < LP_CH;
  assign w_rd_ch   = araddr >> 5;
  assign w_rd_off  = araddr[4:2];
  assign w_rd_ok   = w_rd_ch < LP_CH;

  for (genvar i = 0; i < NB; i++) begin : g_mask
    assign w_mask[i*8 +: 8] = {8{w_strb[i]}};
  end

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_edge   = w_sync & ~r_prev;
  assign w_unused = ^{awprot, arprot, w_waddr[1:0], araddr[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= w_sync;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  w_sel;
    logic [DATA_WIDTH-1:0] w_clr;
    logic [DATA_WIDTH-1:0] r_out, r_dir, r_irq_en, r_irq_stat;

    assign w_sel = w_commit && w_wr_ok && (w_wr_ch == ADDR_WIDTH'(c));
    assign w_clr = (w_sel && w_wr_off == 3'd4) ? (w_wdat & w_mask) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out      <= '0;
        r_dir      <= '0;
        r_irq_en   <= '0;
        r_irq_stat <= '0;
      end else begin
        if (w_sel && w_wr_off == 3'd0) r_out    <= (r_out & ~w_mask) | (w_wdat & w_mask);
        if (w_sel && w_wr_off == 3'd1) r_dir    <= (r_dir & ~w_mask) | (w_wdat & w_mask);
        if (w_sel && w_wr_off == 3'd3) r_irq_en <= (r_irq_en & ~w_mask) | (w_wdat & w_mask);
        // New edges are ORed in after the clear so a coincident edge survives the W1C.
        r_irq_stat <= (r_irq_stat & ~w_clr) | w_edge[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign gpio_out[c*DATA_WIDTH +: DATA_WIDTH]    = r_out;
    assign gpio_oe[c*DATA_WIDTH +: DATA_WIDTH]     = r_dir;
    assign w_en_flat[c*DATA_WIDTH +: DATA_WIDTH]   = r_irq_en;
    assign w_stat_flat[c*DATA_WIDTH +: DATA_WIDTH] = r_irq_stat;
  end

  always_comb begin
    w_rd_dat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_rd_ch == ADDR_WIDTH'(c)) begin
        case (w_rd_off)
          3'd0:    w_rd_dat = gpio_out[c*DATA_WIDTH +: DATA_WIDTH];
          3'd1:    w_rd_dat = gpio_oe[c*DATA_WIDTH +: DATA_WIDTH];
          3'd2:    w_rd_dat = w_sync[c*DATA_WIDTH +: DATA_WIDTH];
          3'd3:    w_rd_dat = w_en_flat[c*DATA_WIDTH +: DATA_WIDTH];
          3'd4:    w_rd_dat = w_stat_flat[c*DATA_WIDTH +: DATA_WIDTH];
          default: w_rd_dat = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else if (w_commit) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_bvalid  <= 1'b1;
      r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
    end else begin
      if (w_aw_fire) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= awaddr;
      end
      if (w_w_fire) begin
        r_w_held <= 1'b1;
        r_wdata  <= wdata;
        r_wstrb  <= wstrb;
      end
      if (r_bvalid && bready) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
      r_irq    <= 1'b0;
    end else begin
      if (w_ar_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_dat;
        r_rresp  <= w_rd_ok ? 2'b00 : 2'b10;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
        r_rdata  <= '0;
      end
      r_irq <= |(w_stat_flat & w_en_flat);
    end
  end
endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank; three channels so an out-of-range channel index is addressable.
module tb_gpio_bank;
  localparam int CH = 3;
  localparam int DW = 32;
  localparam int AW = $clog2(CH) + 5;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready, irq;
  logic [DW-1:0]     wdata, rdata;
  logic [DW/8-1:0]   wstrb;
  logic [1:0]        bresp, rresp;
  logic [CH*DW-1:0]  gpio_out, gpio_oe, gpio_in;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  gpio_bank #(.CHANNELS(CH), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [CH*DW-1:0] obs, input logic [CH*DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_b(input string tag);
    int lat;
    logic [1:0] e;
    lat = 1;
    @(negedge clk);
    while (bvalid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_blat"}, lat, 1);
    e = bq.pop_front();
    check({tag, "_bresp"}, bresp, e);
  endtask

  task automatic axi_write(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp);
    bq.push_back(resp);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    check({tag, "_awwrdy"}, {awready, wready}, 2'b11);
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(tag);
    tick;
    bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [1:0] resp);
    int lat;
    logic [33:0] e;
    rq.push_back({resp, d});
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    check({tag, "_arrdy"}, arready, 1'b1);
    tick;
    arvalid = 1'b0; rready = 1'b1;
    lat = 1;
    @(negedge clk);
    while (rvalid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_rlat"}, lat, 1);
    e = rq.pop_front();
    check({tag, "_rdata"}, rdata, e[31:0]);
    check({tag, "_rresp"}, rresp, e[33:32]);
    tick;
    rready = 1'b0;
    @(negedge clk);
    check({tag, "_ridle"}, {rvalid, rdata}, '0);
    tick;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; gpio_in = '0;
    awaddr = '0; awprot = 3'b0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b0; arvalid = 1'b0; rready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick;
      gpio_in = {$urandom, $urandom, $urandom};
    end
    @(negedge clk);
    check("rst_out", gpio_out, '0);
    check("rst_oe", gpio_oe, '0);
    check("rst_irq", irq, 1'b0);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resp_rdata", {bresp, rresp, rdata}, '0);
    check("rst_readys", {awready, wready, arready}, 3'b111);
    gpio_in = '0;
    tick;
    rst_n = 1'b1;
    tick;

    axi_write("wr_strb", 7'h20, 32'hDEADBEEF, 4'b0101, OKAY);
    check("wr_strb_out", gpio_out, {32'h0, 32'h00AD00EF, 32'h0});

    // W alone, AW three cycles later, bready low for two cycles of bvalid.
    bq.push_back(OKAY);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); check("dec_wrdy", wready, 1'b1);
    tick; wvalid = 1'b0;
    @(negedge clk); check("dec_held", {awready, wready, bvalid}, 3'b100);
    tick;
    tick; awaddr = 7'h00; awvalid = 1'b1;
    @(negedge clk); check("dec_awrdy", awready, 1'b1);
    tick; awvalid = 1'b0;
    @(negedge clk);
    check("dec_bvalid4", {bvalid, awready, wready}, 3'b100);
    check("dec_out", gpio_out[31:0], 32'h12345678);
    check("dec_bresp", bresp, bq.pop_front());
    tick;
    @(negedge clk); check("dec_bvalid5", {bvalid, awready, wready}, 3'b100);
    tick; bready = 1'b1;
    @(negedge clk); check("dec_bvalid6", bvalid, 1'b1);
    tick; bready = 1'b0;
    @(negedge clk); check("dec_bdone", {bvalid, awready, wready}, 3'b011);
    tick;

    axi_write("dir", 7'h04, 32'h0000FFFF, 4'hF, OKAY);
    check("dir_oe", gpio_oe, {64'h0, 32'h0000FFFF});
    gpio_in[31:0] = 32'hA5A5A5A5;
    tick; tick; tick;
    axi_read("rd_in", 7'h08, 32'hA5A5A5A5, OKAY);
    axi_read("rd_dir", 7'h04, 32'h0000FFFF, OKAY);
    axi_read("rd_out1", 7'h20, 32'h00AD00EF, OKAY);
    axi_read("rd_rsvd", 7'h14, 32'h0, OKAY);
    axi_read("rd_in2", 7'h48, 32'h0, OKAY);
    axi_write("wr_ro", 7'h08, 32'hFFFFFFFF, 4'hF, OKAY);
    axi_write("wr_rsvd", 7'h1C, 32'hFFFFFFFF, 4'hF, OKAY);
    axi_read("rd_in_again", 7'h08, 32'hA5A5A5A5, OKAY);

    axi_write("irq_en", 7'h2C, 32'h8, 4'hF, OKAY);
    gpio_in[35] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 3) check("irq_early", irq, 1'b0);
      if (k == 4) check("irq_set", irq, 1'b1);
    end
    tick; gpio_in[35] = 1'b0;
    axi_read("irq_stat", 7'h30, 32'h8, OKAY);
    axi_write("irq_w1c", 7'h30, 32'h8, 4'hF, OKAY);
    @(negedge clk); check("irq_clr", irq, 1'b0);
    tick;
    axi_read("irq_stat_clr", 7'h30, 32'h0, OKAY);

    gpio_in[36] = 1'b1;
    tick; tick; tick; tick;
    gpio_in[36] = 1'b0;
    @(negedge clk); check("irq_masked", irq, 1'b0);
    tick;
    axi_read("stat_noen", 7'h30, 32'h10, OKAY);
    axi_write("stat_noen_clr", 7'h30, 32'h10, 4'hF, OKAY);

    // Pad edge timed so its IRQ_STAT set lands on the W1C commit edge.
    gpio_in[35] = 1'b1;
    tick;
    tick;
    bq.push_back(OKAY);
    awaddr = 7'h30; awvalid = 1'b1; wdata = 32'h8; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk); check("sw_rdy", {awready, wready}, 2'b11);
    tick; awvalid = 1'b0; wvalid = 1'b0;
    wait_b("sw");
    tick; bready = 1'b0;
    axi_read("sw_stat", 7'h30, 32'h8, OKAY);
    check("sw_irq", irq, 1'b1);
    gpio_in[35] = 1'b0;
    axi_write("sw_clr", 7'h30, 32'h8, 4'hF, OKAY);
    axi_read("sw_stat_clr", 7'h30, 32'h0, OKAY);

    axi_read("err_rd", 7'h60, 32'h0, SLVERR);
    axi_write("err_wr", 7'h60, 32'hFFFFFFFF, 4'hF, SLVERR);
    check("err_out", gpio_out, {32'h0, 32'h00AD00EF, 32'h12345678});

    awaddr = 7'h20; awvalid = 1'b1;
    @(negedge clk); check("mid_awrdy", awready, 1'b1);
    tick; awvalid = 1'b0;
    @(negedge clk); check("mid_held", {awready, bvalid}, 2'b00);
    gpio_in = '0;
    rst_n = 1'b0;
    tick; tick;
    check("mid_rst_out", gpio_out, '0);
    check("mid_rst_rdy", {awready, wready, arready}, 3'b111);
    rst_n = 1'b1;
    tick;
    wdata = 32'h5555; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); check("mid_wrdy", wready, 1'b1);
    tick; wvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("mid_no_b", bvalid, 1'b0);
      tick;
    end
    bq.push_back(OKAY);
    awaddr = 7'h20; awvalid = 1'b1; bready = 1'b1;
    @(negedge clk); check("mid_awrdy2", awready, 1'b1);
    tick; awvalid = 1'b0;
    wait_b("mid");
    check("mid_out", gpio_out, {32'h0, 32'h5555, 32'h0});
    tick; bready = 1'b0;
    axi_read("mid_out0", 7'h00, 32'h0, OKAY);
    axi_read("mid_dir0", 7'h04, 32'h0, OKAY);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised AXI4-Lite GPIO controller, the multi-channel successor to the single-register GPIO peripheral. Each channel has an output register, a per-bit direction register, a synchronised input register and rising-edge interrupt capture. The block sits on the peripheral interconnect as an AXI4-Lite slave and drives pads plus one level interrupt to the core.

## Interface
- `CHANNELS`, 2: number of independent GPIO channels (1..16).
- `DATA_WIDTH`, 32: bits per channel and AXI data width (multiple of 8).
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).
- `ADDR_WIDTH`, `$clog2(CHANNELS)+5`: derived byte-address width.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `awaddr`/`awprot`/`awvalid`/`awready`, `wdata`/`wstrb`/`wvalid`/`wready`, `bresp`/`bvalid`/`bready`: AXI4-Lite write channels. Widths: ADDR_WIDTH, 3, DATA_WIDTH, DATA_WIDTH/8, 2.
- `araddr`/`arprot`/`arvalid`/`arready`, `rdata`/`rresp`/`rvalid`/`rready`: AXI4-Lite read channels, same widths.
- `gpio_out` out CHANNELS*DATA_WIDTH: output register values. Channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- `gpio_oe` out CHANNELS*DATA_WIDTH: per-bit output enable (= DIR).
- `gpio_in` in CHANNELS*DATA_WIDTH: asynchronous pad inputs.
- `irq` out 1: level interrupt, registered.

## Operation
- Address decode: byte address, bits [1:0] ignored. Channel = addr[ADDR_WIDTH-1:5]. Word offset = addr[4:2].
- Offsets per channel:
  - 0 OUT (RW)
  - 1 DIR (RW, 1 = output)
  - 2 IN (RO; writes ignored, OKAY)
  - 3 IRQ_EN (RW)
  - 4 IRQ_STAT (RW1C)
  - 5–7 reserved (read 0, writes ignored, OKAY)
- Channel index ≥ CHANNELS: response SLVERR (2'b10), no register change, rdata = 0.
- `awprot`/`arprot` are ignored.
- Writes honour `wstrb` per byte for OUT, DIR and IRQ_EN. For IRQ_STAT, a 1 in a strobed byte clears the bit.
- Input path: each `gpio_in` bit passes through SYNC_STAGES flops (reset 0), then one more flop `prev`. IN reads the synchronised value irrespective of DIR.
- Edge capture: IRQ_STAT[b] sets when sync=1 and prev=0, independent of IRQ_EN. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- `irq` is registered: irq ← OR over all channels of (IRQ_STAT & IRQ_EN).
- Write FSM:
  - AW and W are captured independently into holding registers (aw_held, w_held).
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Commit on the first edge where both are held or handshaking. At that edge the register updates, bvalid sets, and both holds clear.
  - bvalid holds until bready; the next AW/W is accepted the cycle after the B handshake.
- Read FSM:
  - arready = !rvalid.
  - On an AR handshake, rdata, rresp and rvalid are registered at that edge. rdata holds stable until rready.
  - rdata is 0 whenever rvalid = 0.
- Read and write FSMs run independently. A read in the same cycle as a committing write to the same register returns the old value.

## Timing
- Reset values:
  - All registers and synchronisers: 0.
  - gpio_out = 0, gpio_oe = 0, irq = 0.
  - bvalid = 0, rvalid = 0, bresp = 0, rresp = 0, rdata = 0.
  - awready = wready = arready = 1 (while in reset and after).
- Write latency: AW and W handshake in cycle N (together) → register and gpio_out change and bvalid = 1 in cycle N+1.
  - W in N, AW in N+2 → bvalid in N+3.
- Read latency: AR handshake in cycle N → rvalid = 1 in N+1. Back-to-back reads with rready held high: one read every 2 cycles.
- Pad-to-IN latency: SYNC_STAGES cycles.
- Pad edge to IRQ_STAT set: SYNC_STAGES+1 cycles. To irq: SYNC_STAGES+2 cycles.
- Reset mid-transaction: pending AW/W/AR and outstanding B/R are discarded, and no response is issued after reset.

## Test plan
- Reset: hold rst_n=0 with gpio_in toggling → all outputs at reset values. Then write OUT ch1 = 0xDEADBEEF, wstrb=4'b0101, from reset → ch1 gpio_out = 0x00AD00EF, bresp=OKAY, bvalid in the cycle after the AW/W handshake.
- Decoupled AW/W: W in cycle 0, AW in cycle 3, bready low for 2 cycles → bvalid from cycle 4 to B handshake; awready/wready stay low while bvalid is high.
- DIR/IN: DIR ch0 = 0x0000FFFF, gpio_in ch0 = 0xA5A5A5A5 → gpio_oe matches DIR; IN reads 0xA5A5A5A5 after ≥SYNC_STAGES cycles, rvalid one cycle after AR.
- Interrupt: IRQ_EN ch1 bit 3 = 1, pulse gpio_in bit 3 of ch1 high → IRQ_STAT = 0x8 and irq=1 at SYNC_STAGES+2. Write IRQ_STAT = 0x8 → irq=0.
- Set wins over clear: an edge lands on the same cycle as the W1C commit → bit stays set.
- Error/reset: read address 0x40 with CHANNELS=2 → rresp=SLVERR, rdata=0. Assert rst_n mid-write (AW only held) → no bvalid after release, registers 0.
